// File: rtl/dp_pkg.sv
// Shared types for the edu CPU datapath: transfer commands, ALU ops, branch conditions.
package dp_pkg;

  typedef enum logic [3:0] {
    XC_NOP    = 4'h0,
    XC_MA_PC  = 4'h1,
    XC_MEM_RD = 4'h2,
    XC_IR_MD  = 4'h3,
    XC_MA_MD  = 4'h4,
    XC_A_MD   = 4'h5,
    XC_MA_AP  = 4'h6,
    XC_MA_SP  = 4'h7,
    XC_MD_A   = 4'h8,
    XC_MEM_WR = 4'h9,
    XC_A_R    = 4'hA,
    XC_PC_MD  = 4'hB,
    XC_A_IN   = 4'hC,
    XC_OUT_A  = 4'hD,
    XC_PC_AP  = 4'hE,
    XC_MD_PC  = 4'hF
  } xfer_cmd_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SHL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_C      = 2'd2,
    COND_NEVER  = 2'd3
  } cond_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;

  localparam logic [1:0] SP_INC = 2'b01;
  localparam logic [1:0] SP_DEC = 2'b10;

  function automatic logic cond_true(input cond_e cond, input logic [1:0] flags);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_Z:      return flags[FLG_Z];
      COND_C:      return flags[FLG_C];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: ADD/SUB take A or AP as X, every other op works on A; Y is always MD.
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic              sel_ap_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] ap_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] result_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W-1:0] op_x;
  logic [DATA_W:0]   sum_w;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    op_x     = (sel_ap_i && (op_i == ALU_ADD || op_i == ALU_SUB)) ? ap_i : a_i;
    sum_w    = '0;
    result_o = '0;
    c_o      = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        sum_w    = {1'b0, op_x} + {1'b0, y_i};
        result_o = sum_w[DATA_W-1:0];
        c_o      = sum_w[DATA_W];
      end
      // The extra top bit of a widened subtract is the borrow (X < Y).
      ALU_SUB: begin
        sum_w    = {1'b0, op_x} - {1'b0, y_i};
        result_o = sum_w[DATA_W-1:0];
        c_o      = sum_w[DATA_W];
      end
      ALU_NOT: result_o = ~a_i;
      ALU_OR:  result_o = a_i | y_i;
      ALU_AND: result_o = a_i & y_i;
      ALU_XOR: result_o = a_i ^ y_i;
      ALU_SHR: begin
        result_o = a_i >> 1;
        c_o      = a_i[0];
      end
      ALU_SHL: begin
        result_o = a_i << 1;
        c_o      = a_i[DATA_W-1];
      end
    endcase
  end

  assign z_o = (result_o == '0);

endmodule

// File: rtl/param_data_path.sv
// Edu CPU datapath: register file, bounded stack pointer and a req/ack memory port that stalls
// all control inputs while a transaction is in flight.
module param_data_path
  import dp_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int SP_INIT = 'h7F,
  parameter int SP_MIN  = 'h40,
  parameter int SP_MAX  = 'h7F
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [3:0]        i_xfer_cmd,
  input  logic              i_sel_ap,
  input  logic [2:0]        i_alu_op,
  input  logic              i_alu_calc,
  input  logic [1:0]        i_cond,
  input  logic              i_inc_pc,
  input  logic [1:0]        i_sp_op,
  input  logic              i_reset_ir,
  input  logic              i_clr_err,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_ir,
  output logic [DATA_W-1:0] o_out,
  output logic [1:0]        o_flags,
  output logic              o_stack_err
);

  localparam logic [ADDR_W-1:0] SP_INIT_V = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_MIN_V  = ADDR_W'(SP_MIN);
  localparam logic [ADDR_W-1:0] SP_MAX_V  = ADDR_W'(SP_MAX);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ma_q, ma_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] ap_q, ap_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [1:0]        flags_q, flags_d;
  logic              err_q, err_d;

  logic              busy;
  xfer_cmd_e         cmd;
  logic              cond_ok;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_z;

  assign busy    = (state_q == MEM_REQ);
  // A stalled cycle looks like a NOP to the register file.
  assign cmd     = busy ? XC_NOP : xfer_cmd_e'(i_xfer_cmd);
  assign cond_ok = cond_true(cond_e'(i_cond), flags_q);

  dp_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i    (alu_op_e'(i_alu_op)),
    .sel_ap_i(i_sel_ap),
    .a_i     (a_q),
    .ap_i    (ap_q),
    .y_i     (md_q),
    .result_o(alu_res),
    .c_o     (alu_c),
    .z_o     (alu_z)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    pc_d    = pc_q;
    ma_d    = ma_q;
    sp_d    = sp_q;
    ir_d    = ir_q;
    md_d    = md_q;
    a_d     = a_q;
    ap_d    = ap_q;
    r_d     = r_q;
    in_d    = i_in;
    out_d   = out_q;
    flags_d = flags_q;
    err_d   = err_q;

    unique case (state_q)
      MEM_IDLE: begin
        if (cmd == XC_MEM_RD || cmd == XC_MEM_WR) begin
          state_d = MEM_REQ;
          we_d    = (cmd == XC_MEM_WR);
        end
      end
      MEM_REQ: begin
        if (i_mem_ack) begin
          state_d = MEM_IDLE;
          if (!we_q) md_d = i_mem_rdata;
        end
      end
    endcase

    // Increment first so a PC load from the command below overrides it.
    if (!busy && i_inc_pc) pc_d = pc_q + ADDR_W'(1);

    unique case (cmd)
      XC_NOP, XC_MEM_RD, XC_MEM_WR: ;
      XC_MA_PC: ma_d = pc_q;
      XC_IR_MD: ir_d = md_q;
      XC_MA_MD: ma_d = ADDR_W'(md_q);
      XC_A_MD: begin
        if (i_sel_ap) ap_d = md_q;
        else          a_d  = md_q;
      end
      XC_MA_AP: ma_d = ADDR_W'(ap_q);
      XC_MA_SP: ma_d = sp_q;
      XC_MD_A:  md_d = i_sel_ap ? ap_q : a_q;
      XC_A_R: begin
        if (i_sel_ap) ap_d = r_q;
        else          a_d  = r_q;
      end
      XC_PC_MD: if (cond_ok) pc_d = ADDR_W'(md_q);
      XC_A_IN:  a_d   = in_q;
      XC_OUT_A: out_d = a_q;
      XC_PC_AP: pc_d  = ADDR_W'(ap_q);
      XC_MD_PC: md_d  = DATA_W'(pc_q);
    endcase

    if (!busy && i_reset_ir) ir_d = '0;

    if (!busy && i_alu_calc) begin
      r_d            = alu_res;
      flags_d[FLG_C] = alu_c;
      flags_d[FLG_Z] = alu_z;
    end

    // Clear before the bound checks so a same-cycle new error wins.
    if (i_clr_err) err_d = 1'b0;
    if (!busy) begin
      case (i_sp_op)
        SP_INC: begin
          if (sp_q == SP_MAX_V) err_d = 1'b1;
          else                  sp_d  = sp_q + ADDR_W'(1);
        end
        SP_DEC: begin
          if (sp_q == SP_MIN_V) err_d = 1'b1;
          else                  sp_d  = sp_q - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= MEM_IDLE;
      we_q    <= 1'b0;
      pc_q    <= '0;
      ma_q    <= '0;
      sp_q    <= SP_INIT_V;
      ir_q    <= '0;
      md_q    <= '0;
      a_q     <= '0;
      ap_q    <= '0;
      r_q     <= '0;
      in_q    <= '0;
      out_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
      ma_q    <= ma_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
      md_q    <= md_d;
      a_q     <= a_d;
      ap_q    <= ap_d;
      r_q     <= r_d;
      in_q    <= in_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign o_busy      = busy;
  assign o_mem_req   = busy;
  assign o_mem_we    = busy & we_q;
  assign o_mem_addr  = ma_q;
  assign o_mem_wdata = busy ? md_q : '0;
  assign o_ir        = ir_q;
  assign o_out       = out_q;
  assign o_flags     = flags_q;
  assign o_stack_err = err_q;

endmodule

// File: tb/tb_param_data_path.sv
// Directed bench for param_data_path: an 8/8 instance plus a 16/12 instance, checked through a
// scoreboard queue that a negedge monitor drains whenever the driver posts an observation.
module tb_param_data_path;
  import dp_pkg::*;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        sel_ap;
    logic [2:0]  alu_op;
    logic        calc;
    logic [1:0]  cond;
    logic        inc_pc;
    logic [1:0]  sp_op;
    logic        reset_ir;
    logic        clr_err;
    logic [15:0] din;
    logic [15:0] rdata;
    logic        ack;
  } ctrl_t;

  localparam int K_OUT = 0, K_IR = 1, K_FLAGS = 2, K_ERR = 3, K_BUSY = 4, K_REQ = 5, K_WE = 6;
  localparam int K_ADDR = 7, K_WDATA = 8, K_OUT_W = 9, K_FLAGS_W = 10, K_ADDR_W = 11;
  localparam int K_ST_W = 12, K_IR_W = 13, K_WD_W = 14;

  logic  clk = 1'b0;
  logic  rst_n;
  ctrl_t c [2];

  logic [7:0]  out8, ir8, wdata8;
  logic [7:0]  addr8;
  logic [1:0]  flags8;
  logic        err8, busy8, req8, we8;
  logic [15:0] out16, ir16, wdata16;
  logic [11:0] addr16;
  logic [1:0]  flags16;
  logic        err16, busy16, req16, we16;

  int kind_q[$];
  logic [31:0] val_q[$];
  string name_q[$];
  int obs_req = 0;
  int obs_ack = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_tmo = 0;

  always #5 clk = ~clk;

  param_data_path dut8 (
    .i_clk(clk), .i_rstn(rst_n),
    .i_xfer_cmd(c[0].cmd), .i_sel_ap(c[0].sel_ap), .i_alu_op(c[0].alu_op),
    .i_alu_calc(c[0].calc), .i_cond(c[0].cond), .i_inc_pc(c[0].inc_pc),
    .i_sp_op(c[0].sp_op), .i_reset_ir(c[0].reset_ir), .i_clr_err(c[0].clr_err),
    .i_in(c[0].din[7:0]), .i_mem_rdata(c[0].rdata[7:0]), .i_mem_ack(c[0].ack),
    .o_mem_req(req8), .o_mem_we(we8), .o_mem_addr(addr8), .o_mem_wdata(wdata8),
    .o_busy(busy8), .o_ir(ir8), .o_out(out8), .o_flags(flags8), .o_stack_err(err8)
  );

  param_data_path #(.DATA_W(16), .ADDR_W(12)) dut16 (
    .i_clk(clk), .i_rstn(rst_n),
    .i_xfer_cmd(c[1].cmd), .i_sel_ap(c[1].sel_ap), .i_alu_op(c[1].alu_op),
    .i_alu_calc(c[1].calc), .i_cond(c[1].cond), .i_inc_pc(c[1].inc_pc),
    .i_sp_op(c[1].sp_op), .i_reset_ir(c[1].reset_ir), .i_clr_err(c[1].clr_err),
    .i_in(c[1].din), .i_mem_rdata(c[1].rdata), .i_mem_ack(c[1].ack),
    .o_mem_req(req16), .o_mem_we(we16), .o_mem_addr(addr16), .o_mem_wdata(wdata16),
    .o_busy(busy16), .o_ir(ir16), .o_out(out16), .o_flags(flags16), .o_stack_err(err16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: drains every expectation queued since the last observation point.
  always @(negedge clk) begin
    if (obs_ack != obs_req) begin
      while (kind_q.size() > 0) begin
        int k;
        logic [31:0] e;
        logic [31:0] act;
        string n;
        k = kind_q.pop_front();
        e = val_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_OUT:     act = 32'(out8);
          K_IR:      act = 32'(ir8);
          K_FLAGS:   act = 32'(flags8);
          K_ERR:     act = 32'(err8);
          K_BUSY:    act = 32'(busy8);
          K_REQ:     act = 32'(req8);
          K_WE:      act = 32'(we8);
          K_ADDR:    act = 32'(addr8);
          K_WDATA:   act = 32'(wdata8);
          K_OUT_W:   act = 32'(out16);
          K_FLAGS_W: act = 32'(flags16);
          K_ADDR_W:  act = 32'(addr16);
          K_ST_W:    act = {28'd0, err16, busy16, req16, we16};
          K_IR_W:    act = 32'(ir16);
          K_WD_W:    act = 32'(wdata16);
          default:   act = 32'hDEAD_BEEF;
        endcase
        check(n, act, e);
      end
      obs_ack = obs_req;
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] val, input string name);
    kind_q.push_back(kind);
    val_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic observe();
    obs_req++;
    @(negedge clk);
    #1;
    if (obs_ack != obs_req) begin
      n_tmo++;
      $display("FAIL observe_timeout: ack %0d, expected %0d", obs_ack, obs_req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      c[d].cmd      = '0;
      c[d].sel_ap   = 1'b0;
      c[d].calc     = 1'b0;
      c[d].cond     = '0;
      c[d].inc_pc   = 1'b0;
      c[d].sp_op    = '0;
      c[d].reset_ir = 1'b0;
      c[d].clr_err  = 1'b0;
      c[d].ack      = 1'b0;
    end
  endtask

  task automatic do_cmd(input int d, input logic [3:0] cmd, input logic sel);
    c[d].cmd    = cmd;
    c[d].sel_ap = sel;
    tick();
  endtask

  task automatic load_a(input int d, input logic [15:0] v);
    c[d].din = v;
    tick();
    do_cmd(d, XC_A_IN, 1'b0);
  endtask

  // Leaves A == MD == v on the 8-bit instance.
  task automatic load_md(input logic [15:0] v);
    load_a(0, v);
    do_cmd(0, XC_MD_A, 1'b0);
  endtask

  task automatic calc(input int d, input logic [2:0] op, input logic sel);
    c[d].alu_op = op;
    c[d].sel_ap = sel;
    c[d].calc   = 1'b1;
    tick();
  endtask

  // Copies R into A, A into OUT, then checks OUT.
  task automatic expect_r(input int d, input logic [15:0] v, input string name);
    do_cmd(d, XC_A_R, 1'b0);
    do_cmd(d, XC_OUT_A, 1'b0);
    expect_v(d == 0 ? K_OUT : K_OUT_W, 32'(v), name);
    observe();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) c[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    expect_v(K_OUT, 0, "rst_out");     expect_v(K_IR, 0, "rst_ir");
    expect_v(K_FLAGS, 0, "rst_flags"); expect_v(K_ERR, 0, "rst_err");
    expect_v(K_BUSY, 0, "rst_busy");   expect_v(K_REQ, 0, "rst_req");
    expect_v(K_ADDR, 0, "rst_ma");     expect_v(K_WDATA, 0, "rst_wdata");
    expect_v(K_OUT_W, 0, "rst_out_w"); expect_v(K_FLAGS_W, 0, "rst_flags_w");
    expect_v(K_ST_W, 0, "rst_status_w"); expect_v(K_IR_W, 0, "rst_ir_w");
    expect_v(K_WD_W, 0, "rst_wdata_w"); expect_v(K_ADDR_W, 0, "rst_ma_w");
    observe();
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ADDR, 32'h7F, "rst_sp");
    observe();

    // Read at MA=0x10, ack in the third REQ cycle; control inputs during the stall must be ignored
    load_a(0, 16'h10);
    do_cmd(0, XC_MD_A, 1'b0);
    do_cmd(0, XC_MA_MD, 1'b0);
    do_cmd(0, XC_MEM_RD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      c[0].cmd    = XC_A_IN;
      c[0].din    = 16'h77;
      c[0].inc_pc = 1'b1;
      c[0].sp_op  = 2'b10;
      c[0].alu_op = ALU_ADD;
      c[0].calc   = 1'b1;
      if (i == 2) begin
        c[0].ack   = 1'b1;
        c[0].rdata = 16'hA5;
      end
      expect_v(K_BUSY, 1, "rd_busy");
      expect_v(K_REQ, 1, "rd_req");
      expect_v(K_WE, 0, "rd_we");
      expect_v(K_ADDR, 32'h10, "rd_addr");
      observe();
      tick();
    end
    expect_v(K_BUSY, 0, "rd_busy_done");
    expect_v(K_REQ, 0, "rd_req_done");
    expect_v(K_FLAGS, 0, "stall_flags");
    observe();
    do_cmd(0, XC_OUT_A, 1'b0);
    expect_v(K_OUT, 32'h10, "stall_a");
    observe();
    do_cmd(0, XC_MA_PC, 1'b0);
    expect_v(K_ADDR, 32'h00, "stall_pc");
    observe();
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ADDR, 32'h7F, "stall_sp");
    observe();
    do_cmd(0, XC_IR_MD, 1'b0);
    expect_v(K_IR, 32'hA5, "rd_md");
    observe();
    expect_r(0, 16'h00, "stall_r");

    // Ack while idle is ignored; reset_ir beats cmd 3
    c[0].ack   = 1'b1;
    c[0].rdata = 16'h11;
    tick();
    do_cmd(0, XC_IR_MD, 1'b0);
    expect_v(K_IR, 32'hA5, "idle_ack");
    observe();
    c[0].reset_ir = 1'b1;
    do_cmd(0, XC_IR_MD, 1'b0);
    expect_v(K_IR, 32'h00, "reset_ir_wins");
    observe();

    // Minimum-latency write of MD=0xA5 to MA=0x7F
    do_cmd(0, XC_MEM_WR, 1'b0);
    c[0].ack = 1'b1;
    expect_v(K_BUSY, 1, "wr_busy");   expect_v(K_REQ, 1, "wr_req");
    expect_v(K_WE, 1, "wr_we");       expect_v(K_WDATA, 32'hA5, "wr_wdata");
    expect_v(K_ADDR, 32'h7F, "wr_addr");
    observe();
    tick();
    expect_v(K_BUSY, 0, "wr_busy_done"); expect_v(K_REQ, 0, "wr_req_done");
    expect_v(K_WE, 0, "wr_we_done");
    observe();

    // ALU
    load_md(16'h20);
    load_a(0, 16'hF0);
    calc(0, ALU_ADD, 1'b0);
    expect_v(K_FLAGS, 32'b10, "add_flags");
    observe();
    expect_r(0, 16'h10, "add_r");

    load_md(16'h05);
    load_a(0, 16'h05);
    calc(0, ALU_SUB, 1'b0);
    expect_v(K_FLAGS, 32'b01, "sub_zero_flags");
    observe();
    expect_r(0, 16'h00, "sub_zero_r");

    load_a(0, 16'h03);
    calc(0, ALU_SUB, 1'b0);
    expect_v(K_FLAGS, 32'b10, "sub_borrow_flags");
    observe();

    load_a(0, 16'h0F);
    c[0].cmd = XC_A_R;
    calc(0, ALU_XOR, 1'b0);
    do_cmd(0, XC_OUT_A, 1'b0);
    expect_v(K_OUT, 32'hFE, "cmd_a_old_r");
    expect_v(K_FLAGS, 32'b00, "xor_flags");
    observe();
    expect_r(0, 16'h0A, "xor_r");

    do_cmd(0, XC_A_MD, 1'b1);
    load_md(16'h30);
    calc(0, ALU_ADD, 1'b1);
    expect_v(K_FLAGS, 32'b00, "add_ap_flags");
    observe();
    expect_r(0, 16'h35, "add_ap_r");
    calc(0, ALU_SHR, 1'b0);
    expect_v(K_FLAGS, 32'b10, "shr_flags");
    observe();
    expect_r(0, 16'h1A, "shr_r");

    // Stack bounds
    c[0].sp_op = SP_INC;
    tick();
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ERR, 1, "sp_over_err");
    expect_v(K_ADDR, 32'h7F, "sp_over_hold");
    observe();
    c[0].clr_err = 1'b1;
    tick();
    expect_v(K_ERR, 0, "clr_err");
    observe();
    for (int i = 0; i < 63; i++) begin
      c[0].sp_op = SP_DEC;
      tick();
    end
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ADDR, 32'h40, "sp_at_min");
    expect_v(K_ERR, 0, "sp_min_no_err");
    observe();
    c[0].sp_op = SP_DEC;
    tick();
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ERR, 1, "sp_under_err");
    expect_v(K_ADDR, 32'h40, "sp_under_hold");
    observe();
    c[0].sp_op   = SP_DEC;
    c[0].clr_err = 1'b1;
    tick();
    expect_v(K_ERR, 1, "new_err_wins");
    observe();
    c[0].clr_err = 1'b1;
    tick();
    c[0].sp_op = SP_INC;
    tick();
    do_cmd(0, XC_MA_SP, 1'b0);
    expect_v(K_ERR, 0, "clr_err2");
    expect_v(K_ADDR, 32'h41, "sp_inc");
    observe();

    // Branches: PC load beats inc_pc
    load_md(16'h3C);
    calc(0, ALU_SUB, 1'b0);
    expect_v(K_FLAGS, 32'b01, "br_z_set");
    observe();
    c[0].cond   = COND_Z;
    c[0].inc_pc = 1'b1;
    do_cmd(0, XC_PC_MD, 1'b0);
    do_cmd(0, XC_MA_PC, 1'b0);
    expect_v(K_ADDR, 32'h3C, "br_taken");
    observe();
    load_a(0, 16'h3D);
    calc(0, ALU_SUB, 1'b0);
    c[0].cond   = COND_Z;
    c[0].inc_pc = 1'b1;
    do_cmd(0, XC_PC_MD, 1'b0);
    do_cmd(0, XC_MA_PC, 1'b0);
    expect_v(K_ADDR, 32'h3D, "br_not_taken");
    observe();
    c[0].inc_pc = 1'b1;
    do_cmd(0, XC_PC_AP, 1'b0);
    do_cmd(0, XC_MA_PC, 1'b0);
    expect_v(K_ADDR, 32'h05, "pc_ap_wins");
    observe();
    c[0].cond   = COND_NEVER;
    c[0].inc_pc = 1'b1;
    do_cmd(0, XC_PC_MD, 1'b0);
    do_cmd(0, XC_MA_PC, 1'b0);
    expect_v(K_ADDR, 32'h06, "br_never");
    observe();

    // Reset with a read in flight and no ack
    do_cmd(0, XC_MEM_RD, 1'b0);
    expect_v(K_BUSY, 1, "pre_rst_busy");
    expect_v(K_REQ, 1, "pre_rst_req");
    observe();
    tick();
    rst_n = 1'b0;
    expect_v(K_REQ, 0, "midreq_req");   expect_v(K_BUSY, 0, "midreq_busy");
    expect_v(K_WE, 0, "midreq_we");     expect_v(K_ADDR, 0, "midreq_ma");
    expect_v(K_FLAGS, 0, "midreq_flags"); expect_v(K_OUT, 0, "midreq_out");
    observe();
    rst_n = 1'b1;
    tick();
    do_cmd(0, XC_MA_SP, 1'b0);
    do_cmd(0, XC_IR_MD, 1'b0);
    expect_v(K_ADDR, 32'h7F, "midreq_sp");
    expect_v(K_IR, 0, "midreq_md");
    expect_v(K_BUSY, 0, "midreq_idle");
    observe();

    // 16-bit data, 12-bit address instance
    load_a(1, 16'h8001);
    calc(1, ALU_SHL, 1'b0);
    expect_v(K_FLAGS_W, 32'b10, "shl16_flags");
    observe();
    expect_r(1, 16'h0002, "shl16_r");
    load_a(1, 16'h0FFF);
    do_cmd(1, XC_MD_A, 1'b0);
    do_cmd(1, XC_PC_MD, 1'b0);
    do_cmd(1, XC_MA_PC, 1'b0);
    expect_v(K_ADDR_W, 32'hFFF, "pc12_max");
    observe();
    c[1].inc_pc = 1'b1;
    tick();
    do_cmd(1, XC_MA_PC, 1'b0);
    expect_v(K_ADDR_W, 32'h000, "pc12_wrap");
    observe();

    if (kind_q.size() != 0) begin
      n_tmo++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", kind_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + n_tmo);
    $finish;
  end

endmodule
